// File: rtl/up_counter_reader_pkg.sv
// Shared types and constants for the up_counter reader: FSM state encoding,
// default widths and the sample record.
package up_counter_reader_pkg;

    localparam int CNT_W = 8;
    localparam int GAP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLR_HOLD = 2'd1,
        ST_CLR_WAIT = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic [CNT_W-1:0] value;
        logic [CNT_W-1:0] delta;
        logic             wrap;
        logic             clr;
        logic [GAP_W-1:0] gap;
    } sample_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/up_counter_reader_stable_sampler.sv
// Synchronizes the free-running count into clk, filters it for stability and
// flags a stable value that differs from the caller's reference.
module stable_sampler #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             restart,
    input  logic [WIDTH-1:0] ref_val,
    input  logic             first,
    output logic             stable,
    output logic [WIDTH-1:0] stable_val,
    output logic             stable_new
);

    localparam int STAB_W = $clog2(STABLE_CNT + 1);

    logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill_q;
    logic [STAB_W-1:0]      stab_q;

    // fill_q marks stages holding post-reset data, so the reset value of the
    // synchronizer never counts as stable on its own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            fill_q <= '0;
            stab_q <= '0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            if (restart || !fill_q[SYNC_STAGES-1] ||
                (sync_q[SYNC_STAGES-2] != sync_q[SYNC_STAGES-1]))
                stab_q <= '0;
            else if (stab_q != STAB_W'(STABLE_CNT))
                stab_q <= stab_q + 1'b1;
        end
    end

    assign stable_val = sync_q[SYNC_STAGES-1];
    assign stable     = (stab_q == STAB_W'(STABLE_CNT));
    assign stable_new = stable && (first || (stable_val != ref_val));

endmodule

// File: rtl/up_counter_reader.sv
// Clocked reader/controller for the self-timed up_counter: drives enable/clr and
// streams captured counts. Optional smp_gap output with UP_COUNTER_READER_GAP_EN.
module up_counter_reader
    import up_counter_reader_pkg::*;
#(
    parameter int WIDTH       = CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 3,
    parameter int CLR_HOLD    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clr_req,
    output logic             cnt_enable,
    output logic             cnt_clr,
    input  logic [WIDTH-1:0] cnt_out,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic [WIDTH-1:0] smp_value,
    output logic [WIDTH-1:0] smp_delta,
    output logic             smp_wrap,
    output logic             smp_clr,
    output logic             overrun,
    output logic             busy,
`ifdef UP_COUNTER_READER_GAP_EN
    output logic [GAP_W-1:0] smp_gap,
`endif
    output rd_state_e        fsm_state
);

    localparam int HOLD_W = $clog2(max2(CLR_HOLD, SYNC_STAGES) + 1);

    rd_state_e         state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              run_q;
    logic [WIDTH-1:0]  last_acc_q;
    logic              first_q;
    logic              stable, stable_new, restart;
    logic [WIDTH-1:0]  stable_val;
    logic              capture, clr_done, evt, can_load;

    stable_sampler #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .STABLE_CNT (STABLE_CNT)
    ) u_sampler (
        .clk       (clk),
        .reset     (reset),
        .din       (cnt_out),
        .restart   (restart),
        .ref_val   (last_acc_q),
        .first     (first_q),
        .stable    (stable),
        .stable_val(stable_val),
        .stable_new(stable_new)
    );

    // In CLR_WAIT the hold counter first flushes SYNC_STAGES cycles, so a zero
    // seen before cnt_clr fell cannot complete the clear early.
    assign restart  = (state_q == ST_CLR_HOLD) || ((state_q == ST_CLR_WAIT) && (hold_q != '0));
    assign clr_done = (state_q == ST_CLR_WAIT) && (hold_q == '0) && stable && (stable_val == '0);
    assign capture  = (state_q == ST_IDLE) && stable_new;
    assign evt      = capture || clr_done;
    assign can_load = !smp_valid || smp_ready;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLR_HOLD;
                    hold_d  = HOLD_W'(CLR_HOLD);
                end
            end
            ST_CLR_HOLD: begin
                if (hold_q <= HOLD_W'(1)) begin
                    state_d = ST_CLR_WAIT;
                    hold_d  = HOLD_W'(SYNC_STAGES);
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            ST_CLR_WAIT: begin
                if (hold_q != '0) hold_d = hold_q - 1'b1;
                else if (clr_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q      <= 1'b0;
            last_acc_q <= '0;
            first_q    <= 1'b1;
            smp_valid  <= 1'b0;
            smp_value  <= '0;
            smp_delta  <= '0;
            smp_wrap   <= 1'b0;
            smp_clr    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            run_q <= run;
            if (smp_valid && smp_ready) smp_valid <= 1'b0;
            if (evt) begin
                last_acc_q <= capture ? stable_val : '0;
                first_q    <= 1'b0;
                if (can_load) begin
                    smp_valid <= 1'b1;
                    smp_value <= capture ? stable_val : '0;
                    smp_delta <= capture ? (stable_val - last_acc_q) : '0;
                    smp_wrap  <= capture && (stable_val < last_acc_q);
                    smp_clr   <= clr_done;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

`ifdef UP_COUNTER_READER_GAP_EN
    logic [GAP_W-1:0] gap_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_q   <= '0;
            smp_gap <= '0;
        end else begin
            if (evt) gap_q <= '0;
            else if (gap_q != '1) gap_q <= gap_q + 1'b1;
            if (evt && can_load) smp_gap <= gap_q;
        end
    end
`endif

    assign busy       = (state_q != ST_IDLE);
    assign cnt_clr    = (state_q == ST_CLR_HOLD);
    assign cnt_enable = run_q && !busy;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_up_counter_reader.sv
// Directed bench for up_counter_reader; the bench plays the counter by driving
// cnt_out directly and checks samples against hand-computed values.
module tb_up_counter_reader;
    import up_counter_reader_pkg::*;

    logic       clk;
    logic       reset;
    logic       run;
    logic       clr_req;
    logic       cnt_enable;
    logic       cnt_clr;
    logic [7:0] cnt_out;
    logic       smp_valid;
    logic       smp_ready;
    logic [7:0] smp_value;
    logic [7:0] smp_delta;
    logic       smp_wrap;
    logic       smp_clr;
    logic       overrun;
    logic       busy;
`ifdef UP_COUNTER_READER_GAP_EN
    logic [15:0] smp_gap;
`endif
    rd_state_e  fsm_state;

    int checks   = 0;
    int failures = 0;

    up_counter_reader dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .clr_req   (clr_req),
        .cnt_enable(cnt_enable),
        .cnt_clr   (cnt_clr),
        .cnt_out   (cnt_out),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_value (smp_value),
        .smp_delta (smp_delta),
        .smp_wrap  (smp_wrap),
        .smp_clr   (smp_clr),
        .overrun   (overrun),
        .busy      (busy),
`ifdef UP_COUNTER_READER_GAP_EN
        .smp_gap   (smp_gap),
`endif
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic sample_t mk(input logic [7:0] v, input logic [7:0] d,
                                   input logic w, input logic c);
        sample_t s;
        s.value = v;
        s.delta = d;
        s.wrap  = w;
        s.clr   = c;
        s.gap   = '0;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for smp_valid and compares the presented sample.
    task automatic expect_sample(input string tag, input sample_t e, input int budget,
                                 output int lat);
        bit seen = 0;
        lat = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            lat++;
            if (smp_valid) begin
                seen = 1;
                break;
            end
        end
        check({tag, ".seen"}, 32'(seen), 32'(1));
        if (seen) begin
            check({tag, ".value"}, 32'(smp_value), 32'(e.value));
            check({tag, ".delta"}, 32'(smp_delta), 32'(e.delta));
            check({tag, ".wrap"},  32'(smp_wrap),  32'(e.wrap));
            check({tag, ".clr"},   32'(smp_clr),   32'(e.clr));
        end
    endtask

    int lat;
    int hi;
    int vcount;
    logic busy_before;

    initial begin
        reset     = 1'b0;
        run       = 1'b0;
        clr_req   = 1'b0;
        smp_ready = 1'b0;
        cnt_out   = 8'h00;
        repeat (3) tick();
        check("rst.valid",   32'(smp_valid),  0);
        check("rst.enable",  32'(cnt_enable), 0);
        check("rst.clr",     32'(cnt_clr),    0);
        check("rst.overrun", 32'(overrun),    0);
        check("rst.busy",    32'(busy),       0);
        check("rst.value",   32'(smp_value),  0);
        check("rst.state",   32'(fsm_state),  32'(ST_IDLE));

        // first stable value after reset release
        reset = 1'b1;
        expect_sample("first", mk(8'h00, 8'h00, 1'b0, 1'b0), 20, lat);
        check("first.latency", 32'(lat), 6);
        check("first.overrun", 32'(overrun), 0);
        check("first.enable",  32'(cnt_enable), 0);
        smp_ready = 1'b1;
        tick();
        check("first.consumed", 32'(smp_valid), 0);

        // incrementing steps
        for (int v = 8'h10; v <= 8'h13; v++) begin
            cnt_out = 8'(v);
            expect_sample($sformatf("step%0h", v),
                          mk(8'(v), (v == 8'h10) ? 8'h10 : 8'h01, 1'b0, 1'b0), 20, lat);
            check($sformatf("step%0h.latency", v), 32'(lat), 6);
            repeat (20 - lat) tick();
        end

        // wrap across 255->0
        cnt_out = 8'hFE;
        expect_sample("pre_wrap", mk(8'hFE, 8'hEB, 1'b0, 1'b0), 20, lat);
        repeat (10) tick();
        cnt_out = 8'h02;
        expect_sample("wrap", mk(8'h02, 8'h04, 1'b1, 1'b0), 20, lat);
        repeat (5) tick();

        // toggling input must not be captured
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            cnt_out = (i % 2 == 0) ? 8'h55 : 8'hAA;
            repeat (2) begin
                tick();
                if (smp_valid) vcount++;
            end
        end
        check("toggle.no_capture", 32'(vcount), 0);
        cnt_out = 8'h40;
        expect_sample("settle", mk(8'h40, 8'h3E, 1'b0, 1'b0), 20, lat);
        repeat (5) tick();

        // clear while running
        run = 1'b1;
        tick();
        check("run.enable", 32'(cnt_enable), 1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clr.cnt_clr", 32'(cnt_clr),    1);
        check("clr.busy",    32'(busy),       1);
        check("clr.enable",  32'(cnt_enable), 0);
        cnt_out = 8'h00;
        hi = 1;
        for (int i = 0; i < 20; i++) begin
            if (i == 1) clr_req = 1'b1;
            tick();
            clr_req = 1'b0;
            if (!cnt_clr) break;
            hi++;
        end
        check("clr.hold_cycles", 32'(hi), 4);
        lat = 0;
        busy_before = 1'b0;
        for (int i = 0; i < 30; i++) begin
            busy_before = busy;
            tick();
            lat++;
            if (smp_valid) break;
        end
        check("clr.seen",        32'(smp_valid), 1);
        check("clr.value",       32'(smp_value), 0);
        check("clr.delta",       32'(smp_delta), 0);
        check("clr.wrap",        32'(smp_wrap),  0);
        check("clr.smp_clr",     32'(smp_clr),   1);
        check("clr.busy_fall",   32'(busy),      0);
        check("clr.busy_before", 32'(busy_before), 1);
        check("clr.min_latency", 32'(lat >= 6),  1);
        check("clr.enable_back", 32'(cnt_enable), 1);
        repeat (4) tick();
        check("clr.no_requeue", 32'(busy), 0);

        // clear when the count is already zero still yields a clear sample
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        expect_sample("clr0", mk(8'h00, 8'h00, 1'b0, 1'b1), 40, lat);
        repeat (3) tick();

        // overrun: held sample, dropped capture, delta relative to dropped value
        run       = 1'b0;
        smp_ready = 1'b0;
        cnt_out   = 8'h20;
        expect_sample("hold", mk(8'h20, 8'h20, 1'b0, 1'b0), 20, lat);
        check("hold.overrun", 32'(overrun), 0);
        cnt_out = 8'h25;
        repeat (12) tick();
        check("ovr.valid",   32'(smp_valid), 1);
        check("ovr.value",   32'(smp_value), 32'h20);
        check("ovr.delta",   32'(smp_delta), 32'h20);
        check("ovr.overrun", 32'(overrun),   1);
        smp_ready = 1'b1;
        tick();
        check("ovr.consumed", 32'(smp_valid), 0);
        cnt_out = 8'h30;
        expect_sample("after_ovr", mk(8'h30, 8'h0B, 1'b0, 1'b0), 20, lat);
        check("ovr.sticky", 32'(overrun), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
